// File: rtl/mem_arbiter_pkg.sv
// Shared types and default widths for the two-port SRAM arbiter.
// Holds the response-owner encoding and the round-robin pointer encoding.
package mem_arb_pkg;

   localparam int unsigned DEF_DATA_W = 32;
   localparam int unsigned DEF_ADDR_W = 32;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_LSU  = 2'd2
   } owner_e;

   typedef enum logic {
      PTR_IF  = 1'b0,
      PTR_LSU = 1'b1
   } ptr_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch unit, the LSU, the arbiter and the SRAM.
// The arbiter uses the slave modport; the requesters/SRAM side uses master.
interface mem_arbiter_if
   import mem_arb_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned ADDR_W = DEF_ADDR_W
);
   logic              i_if_req;
   logic [ADDR_W-1:0] i_if_addr;
   logic              o_if_gnt;
   logic              o_if_rvalid;
   logic [DATA_W-1:0] o_if_rdata;

   logic              i_lsu_req;
   logic              i_lsu_we;
   logic [ADDR_W-1:0] i_lsu_addr;
   logic [DATA_W-1:0] i_lsu_wdata;
   logic              o_lsu_gnt;
   logic              o_lsu_rvalid;
   logic [DATA_W-1:0] o_lsu_rdata;

   logic [ADDR_W-1:0] o_sram_addr;
   logic              o_sram_wren;
   logic [DATA_W-1:0] o_sram_wdata;
   logic [DATA_W-1:0] i_sram_rdata;

   logic              o_busy;

   modport slave (
      input  i_if_req, i_if_addr,
      input  i_lsu_req, i_lsu_we, i_lsu_addr, i_lsu_wdata,
      input  i_sram_rdata,
      output o_if_gnt, o_if_rvalid, o_if_rdata,
      output o_lsu_gnt, o_lsu_rvalid, o_lsu_rdata,
      output o_sram_addr, o_sram_wren, o_sram_wdata,
      output o_busy
   );

   modport master (
      output i_if_req, i_if_addr,
      output i_lsu_req, i_lsu_we, i_lsu_addr, i_lsu_wdata,
      output i_sram_rdata,
      input  o_if_gnt, o_if_rvalid, o_if_rdata,
      input  o_lsu_gnt, o_lsu_rvalid, o_lsu_rdata,
      input  o_sram_addr, o_sram_wren, o_sram_wdata,
      input  o_busy
   );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-requester round-robin pick with its pointer register.
// The pointer only advances when both sides competed for the same cycle.
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_stop,
   input  logic i_req_if,
   input  logic i_req_lsu,
   output logic o_gnt_if,
   output logic o_gnt_lsu
);

   ptr_e ptr_q;
   ptr_e ptr_d;

   // NOTE: every output of this block gets a default first so no path leaves a latch.
   always_comb begin
      o_gnt_if  = 1'b0;
      o_gnt_lsu = 1'b0;
      ptr_d     = ptr_q;
      if (!i_reset && !i_stop) begin
         if (i_req_if && i_req_lsu) begin
            o_gnt_if  = (ptr_q == PTR_IF);
            o_gnt_lsu = (ptr_q == PTR_LSU);
            ptr_d     = (ptr_q == PTR_IF) ? PTR_LSU : PTR_IF;
         end else begin
            o_gnt_if  = i_req_if;
            o_gnt_lsu = i_req_lsu;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge i_clk) begin
      if (i_reset) ptr_q <= PTR_IF;
      else         ptr_q <= ptr_d;
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and load/store traffic onto one single-port SRAM with
// a fixed one-cycle read latency; a registered owner steers each response.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned ADDR_W = DEF_ADDR_W
)(
   input  logic           i_clk,
   input  logic           i_reset,
   input  logic           i_stop,
   mem_arbiter_if.slave   bus
);

   logic              gnt_if;
   logic              gnt_lsu;
   logic [ADDR_W-1:0] if_word;
   logic [ADDR_W-1:0] lsu_word;
   owner_e            owner_q;

   rr_arb2 u_rr_arb2 (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_stop    (i_stop),
      .i_req_if  (bus.i_if_req),
      .i_req_lsu (bus.i_lsu_req),
      .o_gnt_if  (gnt_if),
      .o_gnt_lsu (gnt_lsu)
   );

   assign bus.o_if_gnt  = gnt_if;
   assign bus.o_lsu_gnt = gnt_lsu;

   assign if_word  = {2'b00, bus.i_if_addr[ADDR_W-1:2]};
   assign lsu_word = {2'b00, bus.i_lsu_addr[ADDR_W-1:2]};

   always_comb begin
      bus.o_sram_addr  = '0;
      bus.o_sram_wren  = 1'b0;
      bus.o_sram_wdata = '0;
      if (gnt_if) begin
         bus.o_sram_addr = if_word;
      end else if (gnt_lsu) begin
         bus.o_sram_addr  = lsu_word;
         bus.o_sram_wren  = bus.i_lsu_we;
         bus.o_sram_wdata = bus.i_lsu_we ? bus.i_lsu_wdata : '0;
      end
   end

   // Owner of the response due next cycle; stores never claim it.
   always_ff @(posedge i_clk) begin
      if (i_reset)                          owner_q <= OWN_NONE;
      else if (gnt_if)                      owner_q <= OWN_IF;
      else if (gnt_lsu && !bus.i_lsu_we)    owner_q <= OWN_LSU;
      else                                  owner_q <= OWN_NONE;
   end

   // Gating with reset kills a response whose read was granted just before reset.
   assign bus.o_if_rvalid  = !i_reset && (owner_q == OWN_IF);
   assign bus.o_lsu_rvalid = !i_reset && (owner_q == OWN_LSU);
   assign bus.o_if_rdata   = bus.o_if_rvalid  ? bus.i_sram_rdata : '0;
   assign bus.o_lsu_rdata  = bus.o_lsu_rvalid ? bus.i_sram_rdata : '0;
   assign bus.o_busy       = !i_reset && (owner_q != OWN_NONE);

endmodule
